// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
//   Bundles the FIFO-side handshake and the serial-side outputs of the
//   FIFO-draining UART transmitter.
//   master : the transmitter (reads FIFO status/data, drives rd/tx/busy/done)
//   slave  : the environment (FIFO + line receiver)
//   Signals:
//     tx_en      1  enable starting new frames
//     fifo_empty 1  FIFO empty flag
//     fifo_data  8  FIFO data_out, valid the cycle after fifo_rd_en
//     fifo_rd_en 1  FIFO read pulse
//     tx         1  serial line, idles high
//     busy       1  transmitter not idle
//     done       1  last cycle of the stop bit
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    input  tx_en, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls one byte at a time out of a synchronous FIFO and sends it as a UART
//   frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
//   Parameters:
//     CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//     PARITY        0 = none, 1 = even, 2 = odd
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   fifo_uart_tx_if.master (tx_en, fifo_empty, fifo_data in;
//           fifo_rd_en, tx, busy, done out)
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input logic             clk,
  input logic             rst,
  fifo_uart_tx_if.master  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       bit_q,   bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q,   par_d;
  logic             tx_q,    tx_d;
  logic             rd_q,    rd_d;
  logic             busy_q;
  logic             bit_end;

  // Parity bit for the frame: even parity makes the total count of ones even.
  function automatic logic parity_bit(input logic [7:0] b);
    if (PARITY == 2) begin
      return ~^b;
    end
    return ^b;
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // tx is registered, so each transition loads the level of the bit being
  // entered; the line therefore changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        bit_d = '0;
        if (bus.tx_en && !bus.fifo_empty) begin
          state_d = REQ;
          rd_d    = 1'b1;
        end
      end

      // FIFO data_out becomes valid during LOAD, one cycle after the pulse.
      REQ: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = bus.fifo_data;
        par_d   = parity_bit(bus.fifo_data);
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = START;
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = rd_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int C = 4;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;   // line level per bit slot, slot 0 = start bit
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_if b0 ();
  fifo_uart_tx_if b1 ();
  fifo_uart_tx_if b2 ();

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  logic tx_s [3];
  logic busy_s [3];
  logic done_s [3];
  assign tx_s[0]   = b0.tx;
  assign tx_s[1]   = b1.tx;
  assign tx_s[2]   = b2.tx;
  assign busy_s[0] = b0.busy;
  assign busy_s[1] = b1.busy;
  assign busy_s[2] = b2.busy;
  assign done_s[0] = b0.done;
  assign done_s[1] = b1.done;
  assign done_s[2] = b2.done;

  // Parity instances see a fixed byte 0x07 on the FIFO data bus.
  assign b1.fifo_data = 8'h07;
  assign b2.fifo_data = 8'h07;

  // 32x8 synchronous FIFO model feeding dut0.
  logic [7:0] mem [32];
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;
  int         fcnt = 0;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       do_rd, do_wr;

  assign do_rd = b0.fifo_rd_en && (fcnt != 0);
  assign do_wr = wr_en && (fcnt != 32);
  assign b0.fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (flush) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= 0;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + 5'd1;
      end
      if (do_rd) begin
        b0.fifo_data <= mem[rp];
        rp           <= rp + 5'd1;
      end
      fcnt <= fcnt + int'(do_wr) - int'(do_rd);
    end
  end

  int rd_cnt = 0;
  always @(negedge clk) begin
    if (b0.fifo_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Called at a negedge. Waits (bounded) for the start bit, then checks every
  // cycle of the frame. drop_k/rst_k >= 0 inject tx_en=0 or reset at that cycle.
  task automatic check_frame(input int sel, input logic [10:0] bits, input int nb,
                             input string nm, input int drop_k, input int rst_k,
                             output int gap);
    int errs;
    int dn_errs;
    int first_bad;
    int lastk;
    gap = 0;
    while (tx_s[sel] === 1'b1 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 200) begin
      total++;
      bad++;
      $display("FAIL %s start: tx stayed high %0d cycles, required a start bit", nm, gap);
      return;
    end
    errs      = 0;
    dn_errs   = 0;
    first_bad = -1;
    lastk     = nb * C - 1;
    for (int k = 0; k <= lastk; k++) begin
      if (k == rst_k) begin
        chk({nm, " pre-reset shape errs"}, 32'(errs), 32'd0);
        rst = 1'b0;
        #1;
        chk({nm, " async reset tx/busy/done/rd"},
            32'({tx_s[sel], busy_s[sel], done_s[sel], b0.fifo_rd_en}), 32'b1000);
        return;
      end
      if (k == drop_k) b0.tx_en = 1'b0;
      if (tx_s[sel] !== bits[k / C] || busy_s[sel] !== 1'b1) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      if (done_s[sel] !== (k == lastk)) dn_errs++;
      @(negedge clk);
    end
    if (errs != 0) $display("  %s first bad cycle %0d", nm, first_bad);
    chk({nm, " shape errs"}, 32'(errs), 32'd0);
    chk({nm, " done errs"}, 32'(dn_errs), 32'd0);
    chk({nm, " after frame tx/busy"}, 32'({tx_s[sel], busy_s[sel]}), 32'b10);
  endtask

  vec_t tbl [10];
  int   gap;
  int   r0;
  int   lows;

  initial begin
    tbl[0] = '{8'hA5, 11'b0_1_10100101_0};
    tbl[1] = '{8'h00, 11'b0_1_00000000_0};
    tbl[2] = '{8'hFF, 11'b0_1_11111111_0};
    tbl[3] = '{8'h3C, 11'b0_1_00111100_0};
    tbl[4] = '{8'h12, 11'b0_1_00010010_0};
    tbl[5] = '{8'h80, 11'b0_1_10000000_0};
    tbl[6] = '{8'h01, 11'b0_1_00000001_0};
    tbl[7] = '{8'h5A, 11'b0_1_01011010_0};
    tbl[8] = '{8'hC3, 11'b0_1_11000011_0};
    tbl[9] = '{8'h99, 11'b0_1_10011001_0};

    rst           = 1'b0;
    wr_en         = 1'b0;
    wr_data       = '0;
    flush         = 1'b1;
    b0.tx_en      = 1'b0;
    b1.tx_en      = 1'b0;
    b2.tx_en      = 1'b0;
    b1.fifo_empty = 1'b1;
    b2.fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;

    // Reset held with a full FIFO and tx_en high.
    b0.tx_en = 1'b1;
    for (int i = 0; i < 32; i++) push(8'(i));
    for (int i = 0; i < 5; i++) begin
      chk("reset tx/rd/busy/done", 32'({b0.tx, b0.fifo_rd_en, b0.busy, b0.done}), 32'b1000);
      @(negedge clk);
    end
    b0.tx_en = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 with latency checks.
    push(tbl[0].data);
    @(negedge clk);
    chk("idle before enable tx/rd/busy", 32'({b0.tx, b0.fifo_rd_en, b0.busy}), 32'b100);
    r0 = rd_cnt;
    b0.tx_en = 1'b1;
    @(negedge clk);
    chk("rd pulse edge1", 32'({b0.fifo_rd_en, b0.busy}), 32'b11);
    @(negedge clk);
    chk("rd low edge2 tx high", 32'({b0.fifo_rd_en, b0.tx}), 32'b01);
    @(negedge clk);
    chk("tx low edge3", 32'(b0.tx), 32'd0);
    check_frame(0, tbl[0].bits, 10, "A5", -1, -1, gap);
    chk("A5 rd count", 32'(rd_cnt - r0), 32'd1);
    b0.tx_en = 1'b0;

    // Back-to-back frames.
    for (int i = 1; i <= 3; i++) push(tbl[i].data);
    r0 = rd_cnt;
    b0.tx_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check_frame(0, tbl[i].bits, 10, $sformatf("b2b%0d", i), -1, -1, gap);
      chk($sformatf("b2b%0d gap", i), 32'(gap), 32'd3);
    end
    repeat (20) @(negedge clk);
    chk("b2b rd count", 32'(rd_cnt - r0), 32'd3);
    chk("b2b fifo empty", 32'(fcnt), 32'd0);
    chk("b2b idle busy", 32'(b0.busy), 32'd0);
    b0.tx_en = 1'b0;

    // Empty FIFO with tx_en high.
    r0 = rd_cnt;
    lows = 0;
    b0.tx_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (b0.tx !== 1'b1 || b0.busy !== 1'b0) lows++;
      @(negedge clk);
    end
    chk("empty: tx low/busy cycles", 32'(lows), 32'd0);
    chk("empty: rd count", 32'(rd_cnt - r0), 32'd0);
    b0.tx_en = 1'b0;

    // Four bytes queued with tx_en low, then enabled.
    for (int i = 4; i <= 7; i++) push(tbl[i].data);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (b0.tx !== 1'b1 || b0.busy !== 1'b0) lows++;
      @(negedge clk);
    end
    chk("disabled: tx low/busy cycles", 32'(lows), 32'd0);
    chk("disabled: rd count", 32'(rd_cnt - r0), 32'd0);
    b0.tx_en = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      check_frame(0, tbl[i].bits, 10, $sformatf("q%0d", i), -1, -1, gap);
      chk($sformatf("q%0d gap", i), 32'(gap), 32'd3);
    end
    chk("queued rd count", 32'(rd_cnt - r0), 32'd4);
    chk("queued fifo empty", 32'(fcnt), 32'd0);
    b0.tx_en = 1'b0;

    // tx_en dropped during DATA: frame completes, no further read.
    push(tbl[8].data);
    push(tbl[9].data);
    r0 = rd_cnt;
    b0.tx_en = 1'b1;
    check_frame(0, tbl[8].bits, 10, "C3 drop", C + 2, -1, gap);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      if (b0.tx !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("drop: tx low after", 32'(lows), 32'd0);
    chk("drop: rd count", 32'(rd_cnt - r0), 32'd1);
    chk("drop: fifo level", 32'(fcnt), 32'd1);

    // Reset during DATA of 0x99; then 0x66 goes out, 0x99 is not resent.
    push(8'h66);
    r0 = rd_cnt;
    b0.tx_en = 1'b1;
    check_frame(0, tbl[9].bits, 10, "99 rst", -1, 3 * C, gap);
    @(negedge clk);
    chk("held reset tx/busy/rd", 32'({b0.tx, b0.busy, b0.fifo_rd_en}), 32'b100);
    rst = 1'b1;
    check_frame(0, 11'b0_1_01100110_0, 10, "66 after rst", -1, -1, gap);
    chk("66 gap", 32'(gap), 32'd3);
    chk("rst rd count", 32'(rd_cnt - r0), 32'd2);
    chk("rst fifo empty", 32'(fcnt), 32'd0);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (b0.tx !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("no resend", 32'(lows), 32'd0);
    b0.tx_en = 1'b0;

    // Even parity, byte 0x07 -> parity 1.
    b1.fifo_empty = 1'b0;
    b1.tx_en      = 1'b1;
    @(negedge clk);
    chk("even rd pulse", 32'(b1.fifo_rd_en), 32'd1);
    b1.fifo_empty = 1'b1;
    b1.tx_en      = 1'b0;
    check_frame(1, 11'b1_1_00000111_0, 11, "even 07", -1, -1, gap);

    // Odd parity, byte 0x07 -> parity 0.
    b2.fifo_empty = 1'b0;
    b2.tx_en      = 1'b1;
    @(negedge clk);
    chk("odd rd pulse", 32'(b2.fifo_rd_en), 32'd1);
    b2.fifo_empty = 1'b1;
    b2.tx_en      = 1'b0;
    check_frame(2, 11'b1_0_00000111_0, 11, "odd 07", -1, -1, gap);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
